// File: rtl/tms_progmem_loader.sv
// -----------------------------------------------------------------------------
// tms_progmem_loader
//
// Wishbone slave used by the management core to load, verify and launch a
// TMS1x00 program. It owns the 8-bit program SRAM port. While RUN is low, the
// port serves bus loads and verifies. While RUN is high, it serves core
// instruction fetches and the core is released from reset.
//
// Register map (offsets within the 16 KiB block):
//   0x0000         CTRL    W: bit0 RUN, bit1 CSUM_CLR (self-clearing)
//                          R: {31'b0, RUN}
//   0x0004         STATUS  R: {CSUM[15:0], 14'b0, ERR, RUN}
//                          W: bit1=1 clears ERR
//   0x2000-0x3FFF  program memory window, one byte per 32-bit word
//   other          writes ignored, reads return 0
//
// Ports:
//   wb_clk_i, rst_n        clock, asynchronous active-low reset
//   wbs_*                  Wishbone classic slave (registered ack/data)
//   mem_addr_o             SRAM address: core_pc_i while running, else bus
//   mem_wdata_o/mem_we_o   SRAM write data / write strobe
//   mem_rdata_i            SRAM read data, one cycle after address
//   core_pc_i              core fetch address
//   core_rst_n_o           core reset, low holds the core
// -----------------------------------------------------------------------------
module tms_progmem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          AW        = 11
) (
    input  logic          wb_clk_i,
    input  logic          rst_n,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          mem_we_o,
    input  logic [7:0]    mem_rdata_i,
    input  logic [AW-1:0] core_pc_i,
    output logic          core_rst_n_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MRD  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // 16-bit wrapping byte checksum used for the firmware load check
    function automatic logic [15:0] csum_add(input logic [15:0] csum,
                                             input logic [7:0]  data);
        csum_add = csum + {8'h00, data};
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;

    logic          run_r;
    logic          err_r;
    logic [15:0]   csum_r;
    logic          ack_r;
    logic [31:0]   dat_r;
    logic          mem_we_r;
    logic          core_rst_n_r;

    logic          run_nxt_s;
    logic          err_nxt_s;
    logic [15:0]   csum_nxt_s;
    logic          ack_nxt_s;
    logic [31:0]   dat_nxt_s;
    logic          mem_we_nxt_s;

    logic          decode_s;
    logic          req_s;
    logic [11:0]   off_s;
    logic          is_ctrl_s;
    logic          is_status_s;
    logic          is_mem_s;
    logic          reg_wr_s;
    logic [31:0]   reg_rd_s;
    logic          unused_s;

    assign decode_s    = (wbs_adr_i[31:14] == BASE_ADDR[31:14]);
    assign req_s       = wbs_cyc_i & wbs_stb_i & decode_s;
    assign off_s       = wbs_adr_i[13:2];
    assign is_ctrl_s   = (off_s == 12'h000);
    assign is_status_s = (off_s == 12'h001);
    assign is_mem_s    = wbs_adr_i[13];
    // Register writes only act on a request that enables byte lane 0
    assign reg_wr_s    = req_s & wbs_we_i & wbs_sel_i[0];

    assign unused_s = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    // While running, the core owns the SRAM address; the bus only sees zeros
    assign mem_addr_o   = run_r ? core_pc_i : wbs_adr_i[AW+1:2];
    assign mem_wdata_o  = wbs_dat_i[7:0];
    assign mem_we_o     = mem_we_r;
    assign wbs_ack_o    = ack_r;
    assign wbs_dat_o    = dat_r;
    assign core_rst_n_o = core_rst_n_r;

    // Readback value of the control/status registers for the current offset
    always_comb begin
        reg_rd_s = 32'h0000_0000;
        if (is_ctrl_s) begin
            reg_rd_s = {30'b0, 1'b0, run_r};
        end else if (is_status_s) begin
            reg_rd_s = {csum_r, 14'b0, err_r, run_r};
        end else begin
            reg_rd_s = 32'h0000_0000;
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: memory reads take one extra wait cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (is_mem_s && !wbs_we_i) begin
                        state_nxt_s = ST_MRD;
                    end else begin
                        state_nxt_s = ST_ACK;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MRD:  state_nxt_s = ST_ACK;
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs and registers
    always_comb begin
        run_nxt_s    = run_r;
        err_nxt_s    = err_r;
        csum_nxt_s   = csum_r;
        ack_nxt_s    = 1'b0;
        dat_nxt_s    = dat_r;
        mem_we_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && !(is_mem_s && !wbs_we_i)) begin
                    ack_nxt_s = 1'b1;
                    if (wbs_we_i) begin
                        dat_nxt_s = 32'h0000_0000;
                    end else begin
                        dat_nxt_s = reg_rd_s;
                    end
                    // Strobe lines up exactly with the ack cycle
                    mem_we_nxt_s = wbs_we_i & is_mem_s & wbs_sel_i[0] & ~run_r;
                end else begin
                    ack_nxt_s = 1'b0;
                end
            end
            ST_MRD: begin
                ack_nxt_s = 1'b1;
                if (run_r) begin
                    dat_nxt_s = 32'h0000_0000;
                end else begin
                    dat_nxt_s = {24'h00_0000, mem_rdata_i};
                end
            end
            ST_ACK: begin
                if (req_s) begin
                    // Set has priority over the firmware clear
                    if (is_mem_s && run_r) begin
                        err_nxt_s = 1'b1;
                    end else if (reg_wr_s && is_status_s && wbs_dat_i[1]) begin
                        err_nxt_s = 1'b0;
                    end else begin
                        err_nxt_s = err_r;
                    end

                    if (reg_wr_s && is_ctrl_s) begin
                        run_nxt_s = wbs_dat_i[0];
                    end else begin
                        run_nxt_s = run_r;
                    end

                    if (reg_wr_s && is_ctrl_s && wbs_dat_i[1]) begin
                        csum_nxt_s = 16'h0000;
                    end else if (mem_we_r) begin
                        csum_nxt_s = csum_add(csum_r, wbs_dat_i[7:0]);
                    end else begin
                        csum_nxt_s = csum_r;
                    end
                end else begin
                    err_nxt_s  = err_r;
                    run_nxt_s  = run_r;
                    csum_nxt_s = csum_r;
                end
            end
            default: begin
                ack_nxt_s    = 1'b0;
                mem_we_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and control/status registers; core reset follows RUN's new value
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            run_r        <= 1'b0;
            err_r        <= 1'b0;
            csum_r       <= 16'h0000;
            ack_r        <= 1'b0;
            dat_r        <= 32'h0000_0000;
            mem_we_r     <= 1'b0;
            core_rst_n_r <= 1'b0;
        end else begin
            run_r        <= run_nxt_s;
            err_r        <= err_nxt_s;
            csum_r       <= csum_nxt_s;
            ack_r        <= ack_nxt_s;
            dat_r        <= dat_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            core_rst_n_r <= run_nxt_s;
        end
    end

endmodule

// File: tb/tb_tms_progmem_loader.sv
`timescale 1ns/1ps
module tb_tms_progmem_loader;

    localparam int AW = 11;

    logic          clk;
    logic          rst_n;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [3:0]    sel;
    logic [31:0]   adr;
    logic [31:0]   wdat;
    logic          ack;
    logic [31:0]   rdat;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic [AW-1:0] core_pc;
    logic          core_rst_n;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [7:0]    sram [0:(1<<AW)-1];

    logic [31:0]   x_rdata;
    int            x_lat;
    logic          x_we;
    logic [AW-1:0] x_addr;
    int            we_before;

    tms_progmem_loader #(.BASE_ADDR(32'h3000_0000), .AW(AW)) dut (
        .wb_clk_i     (clk),
        .rst_n        (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .mem_rdata_i  (mem_rdata),
        .core_pc_i    (core_pc),
        .core_rst_n_o (core_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM model: one-cycle read latency, write on strobe
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            sram[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        mem_rdata <= sram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One Wishbone classic cycle; x_lat = cycles from request to ack, -1 on timeout
    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w);
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        x_lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                x_lat   = i;
                x_rdata = rdat;
                x_we    = mem_we;
                x_addr  = mem_addr;
                break;
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 8'h00;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0; core_pc = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_core_rst_n", {31'b0, core_rst_n}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        wb_xfer(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("rst_status", x_rdata, 32'h0000_0000);
        check("reg_rd_lat", x_lat, 32'd1);

        // Load two bytes at the window boundaries
        we_before = we_cnt;
        wb_xfer(32'h3000_2000, 32'h0000_00A5, 4'hF, 1'b1);
        check("wr0_lat", x_lat, 32'd1);
        check("wr0_we", {31'b0, x_we}, 32'h1);
        check("wr0_addr", {21'b0, x_addr}, 32'd0);
        wb_xfer(32'h3000_3FFC, 32'h0000_003C, 4'hF, 1'b1);
        check("wr1_lat", x_lat, 32'd1);
        check("wr1_we", {31'b0, x_we}, 32'h1);
        check("wr1_addr", {21'b0, x_addr}, 32'd2047);
        check("wr_pulses", we_cnt - we_before, 32'd2);
        check("sram_2047", {24'b0, sram[2047]}, 32'h3C);
        wb_xfer(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("status_csum", x_rdata, 32'h00E1_0000);

        // Verify read
        we_before = we_cnt;
        wb_xfer(32'h3000_3FFC, 32'h0, 4'hF, 1'b0);
        check("mrd_lat", x_lat, 32'd2);
        check("mrd_data", x_rdata, 32'h0000_003C);
        check("mrd_no_we", we_cnt - we_before, 32'd0);

        // Launch
        core_pc = 11'h123;
        wb_xfer(32'h3000_0000, 32'h0000_0001, 4'hF, 1'b1);
        check("run_lat", x_lat, 32'd1);
        @(negedge clk);
        check("run_core_rst_n", {31'b0, core_rst_n}, 32'h1);
        check("run_mem_addr", {21'b0, mem_addr}, 32'h123);
        wb_xfer(32'h3000_0000, 32'h0, 4'hF, 1'b0);
        check("ctrl_rd", x_rdata, 32'h0000_0001);

        // Memory accesses while running are blocked and flagged
        we_before = we_cnt;
        wb_xfer(32'h3000_2004, 32'h0000_0077, 4'hF, 1'b1);
        check("run_wr_lat", x_lat, 32'd1);
        check("run_wr_we", {31'b0, x_we}, 32'h0);
        check("run_wr_pulses", we_cnt - we_before, 32'd0);
        wb_xfer(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("status_err", x_rdata, 32'h00E1_0003);
        wb_xfer(32'h3000_2000, 32'h0, 4'hF, 1'b0);
        check("run_rd_lat", x_lat, 32'd2);
        check("run_rd_data", x_rdata, 32'h0);

        // Clear ERR, then stop and clear checksum in one write
        wb_xfer(32'h3000_0004, 32'h0000_0002, 4'hF, 1'b1);
        wb_xfer(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("err_clr", x_rdata, 32'h00E1_0001);
        wb_xfer(32'h3000_0000, 32'h0000_0002, 4'hF, 1'b1);
        @(negedge clk);
        check("stop_core_rst_n", {31'b0, core_rst_n}, 32'h0);
        wb_xfer(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("stop_status", x_rdata, 32'h0000_0000);

        // Lane 0 disabled: no write, checksum unchanged
        we_before = we_cnt;
        wb_xfer(32'h3000_2008, 32'h0000_0055, 4'b1110, 1'b1);
        check("sel_we", {31'b0, x_we}, 32'h0);
        check("sel_pulses", we_cnt - we_before, 32'd0);
        wb_xfer(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("sel_status", x_rdata, 32'h0000_0000);

        // Reset in the middle of a memory read
        wb_xfer(32'h3000_2000, 32'h0000_0011, 4'hF, 1'b1);
        wb_xfer(32'h3000_0000, 32'h0000_0001, 4'hF, 1'b1);
        @(negedge clk);
        check("pre_rst_core", {31'b0, core_rst_n}, 32'h1);
        adr = 32'h3000_2000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ack", {31'b0, ack}, 32'h0);
        check("midrst_core", {31'b0, core_rst_n}, 32'h0);
        check("midrst_we", {31'b0, mem_we}, 32'h0);
        @(negedge clk);
        check("midrst_ack2", {31'b0, ack}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        wb_xfer(32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("midrst_status", x_rdata, 32'h0000_0000);
        wb_xfer(32'h3000_2000, 32'h0, 4'hF, 1'b0);
        check("retry_data", x_rdata, 32'h0000_0011);

        // Unmapped offset
        wb_xfer(32'h3000_0100, 32'h0, 4'hF, 1'b0);
        check("unmap_lat", x_lat, 32'd1);
        check("unmap_data", x_rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tms_progmem_loader.md
# tms_progmem_loader

Wishbone slave inside the TMS1x00 user-project wrapper that lets the Caravel management core load, verify and launch a TMS1x00 program. Sits between the management Wishbone bus and the core's 8-bit program SRAM. It multiplexes the SRAM port between bus access (load/verify) and core instruction fetch (run), and holds the core in reset until firmware sets RUN. A running checksum and a sticky error flag give firmware a cheap load check before it reports test stages on GPIO.

## Interface
- BASE_ADDR, 32'h3000_0000, block base; decode on wbs_adr_i[31:14] == BASE_ADDR[31:14]
- AW, 11, program SRAM address width (2^AW bytes)

- wb_clk_i  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic request
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  registered single-cycle ack
- wbs_dat_o  out  32  registered read data
- mem_addr_o  out  AW  SRAM address (combinational mux)
- mem_wdata_o  out  8  SRAM write data = wbs_dat_i[7:0]
- mem_we_o  out  1  SRAM write strobe
- mem_rdata_i  in  8  SRAM read data, valid 1 cycle after address
- core_pc_i  in  AW  core fetch address
- core_rst_n_o  out  1  core reset, low = held

## Operation
- Decoded offsets: 0x0000 CTRL, 0x0004 STATUS, 0x2000–0x3FFF memory window (byte index = wbs_adr_i[AW+1:2], data in bits[7:0], upper read bits 0). Other in-block offsets: write ignored, read 0, normal ack.
- CTRL write: bit0 → RUN; bit1 = CSUM_CLR (self-clearing, zeroes checksum). Read: {30'b0, 1'b0, RUN}.
- STATUS read: {CSUM[15:0], 14'b0, ERR, RUN}. Write with bit1=1 clears ERR.
- Writes to CTRL/STATUS take effect only if wbs_sel_i[0]=1.
- FSM states IDLE, MRD, ACK:
  - IDLE: request = cyc&stb&decode. Memory read → MRD; anything else → ACK.
  - MRD: one wait cycle; capture mem_rdata_i (or 0 if RUN) → ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, register side effects applied → IDLE.
- Memory write: mem_we_o=1 only in ACK, only if wbs_sel_i[0]=1 and RUN=0; CSUM <= CSUM + wbs_dat_i[7:0] (16-bit wrap) on the same edge.
- mem_addr_o = RUN ? core_pc_i : wbs_adr_i[AW+1:2].
- Memory access while RUN=1: write suppressed, read data 0, ERR set, ack timing unchanged.
- core_rst_n_o registered from RUN: rises/falls one cycle after the CTRL-write ack cycle.
- CSUM_CLR and RUN in one write: both apply. ERR set and clear in one cycle: set wins.

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0, mem_we_o 0, core_rst_n_o 0, RUN 0, ERR 0, CSUM 0, FSM IDLE.
- Request seen at edge N: register access / memory write ack high during cycle N+1; memory read ack high during cycle N+2.
- A new request is accepted in the cycle after ack (master drops stb after ack per classic protocol).
- rst_n asserted mid-transaction: immediate return to reset values, no ack issued; master retries.
- mem_we_o never high while RUN=1 or outside ACK.

## Test plan
- Reset: rst_n low then high → ack 0, mem_we_o 0, core_rst_n_o 0, STATUS reads 0x0000_0000.
- Write 0xA5 to offset 0x2000, 0x3C to offset 0x3FFC → one mem_we_o pulse each at addr 0 / 2047, ack one cycle after stb; STATUS = 0x00E1_0000.
- Read offset 0x3FFC with SRAM model → ack 2 cycles after stb, wbs_dat_o = 0x0000_003C.
- Write CTRL=0x1, core_pc_i=0x123 → core_rst_n_o high one cycle after ack, mem_addr_o=0x123; then write 0x77 to 0x2004 → no mem_we_o, STATUS = 0x00E1_0003.
- Write STATUS=0x2 and CTRL=0x2 → ERR 0, CSUM 0, RUN 0, core_rst_n_o low next cycle; write with wbs_sel_i=4'b1110 to 0x2008 → no mem_we_o, CSUM stays 0.
- Start memory read, pull rst_n low during MRD → no ack, outputs at reset values; unmapped offset 0x0100 read → 0, ack in one cycle.
